// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: synchronises start/goal inputs and sequences the
// match through serve, play, point and win, driving the divider's start/win/score controls.
module pong_game_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4,
  parameter int SERVE_DELAY = 50000000,
  parameter int DLY_W       = 26
) (
  input  logic               CLK_100MHz,
  input  logic               Reset,
  input  logic               btn_start,
  input  logic               goal_l,
  input  logic               goal_r,
  output logic               start,
  output logic               win,
  output logic               score,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               winner
);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, WON} state_t;

  localparam logic [DLY_W-1:0]   DLY_LOAD = DLY_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  state_t            state, next_state;
  logic [DLY_W-1:0]  dly_cnt;
  logic [2:0]        in_s1, in_s2, in_prev;
  logic [2:0]        in_ev;
  logic              btn_ev, gl_ev, gr_ev;
  logic              win_reached;
  logic              start_d, win_d, score_d, winner_d;

  // bit 0 = btn_start, bit 1 = goal_l, bit 2 = goal_r
  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      in_s1   <= '0;
      in_s2   <= '0;
      in_prev <= '0;
    end else begin
      in_s1   <= {goal_r, goal_l, btn_start};
      in_s2   <= in_s1;
      in_prev <= in_s2;
    end
  end

  assign in_ev  = in_s2 & ~in_prev;
  assign btn_ev = in_ev[0];
  assign gl_ev  = in_ev[1];
  assign gr_ev  = in_ev[2];

  assign win_reached = (score_l == WIN_VAL) || (score_r == WIN_VAL);

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (btn_ev) next_state = SERVE;
      SERVE:   if (dly_cnt == '0) next_state = PLAY;
      PLAY:    if (gl_ev || gr_ev) next_state = POINT;
      POINT:   next_state = win_reached ? WON : SERVE;
      WON:     if (btn_ev) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they change on the entering edge.
  always_comb begin
    start_d  = (next_state == PLAY) || (next_state == POINT) || (next_state == WON);
    win_d    = (next_state == WON);
    score_d  = (next_state == POINT);
    winner_d = 1'b0;
    if (next_state == WON) begin
      if (state == POINT) winner_d = (score_r == WIN_VAL);
      else                winner_d = winner;
    end
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      start  <= 1'b0;
      win    <= 1'b0;
      score  <= 1'b0;
      winner <= 1'b0;
    end else begin
      start  <= start_d;
      win    <= win_d;
      score  <= score_d;
      winner <= winner_d;
    end
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      dly_cnt <= '0;
    end else if (state != SERVE && next_state == SERVE) begin
      dly_cnt <= DLY_LOAD;
    end else if (state == SERVE && dly_cnt != '0) begin
      dly_cnt <= dly_cnt - 1'b1;
    end
  end

  // goal_l has priority when both goals land in the same cycle.
  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      score_l <= '0;
      score_r <= '0;
    end else if (state == IDLE && btn_ev) begin
      score_l <= '0;
      score_r <= '0;
    end else if (state == PLAY) begin
      if (gl_ev) begin
        if (score_r < WIN_VAL) score_r <= score_r + 1'b1;
      end else if (gr_ev) begin
        if (score_l < WIN_VAL) score_l <= score_l + 1'b1;
      end
    end
  end

endmodule
